// File: rtl/rv32i_types.sv
// Shared CPU-side types: the 32-bit word plus the arbiter's state, side and
// captured-request types.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // Arbiter sequencing: wait for a requester, run one physical access,
    // then spend exactly one cycle returning the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which CPU port owns the physical port.
    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } arb_side_t;

    // Everything the physical port needs, frozen at grant time.
    typedef struct packed {
        rv32i_word  addr;
        logic [3:0] be;
        rv32i_word  wdata;
        logic       is_write;
    } arb_req_t;

endpackage

// File: rtl/arb_req_reg.sv
// Request-capture register: loads the granted side's request when load is
// high and otherwise holds it, so CPU-side changes mid-access never reach
// the physical port.
module arb_req_reg
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  arb_req_t req_in,
    output arb_req_t req_out
);

    arb_req_t req_d;
    arb_req_t req_q;

    // Next value: new request on load, otherwise hold.
    always_comb begin
        req_d = req_q;
        if (load) begin
            req_d = req_in;
        end
    end

    // Storage with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req_out = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Merges the CPU's instruction and data memory ports onto one physical port.
// One access is in flight at a time; conflicts are resolved round-robin or
// with fixed data priority, and the response is a registered one-cycle pulse
// steered back to the side that was granted.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter bit RR_ENABLE        = 1'b1,
    parameter bit FIRST_GRANT_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_mem_address,
    input  logic        inst_mem_read,
    input  logic        inst_mem_write,
    input  logic [3:0]  inst_mem_byte_enable,
    input  logic [31:0] inst_mem_wdata,
    output logic [31:0] inst_mem_rdata,
    output logic        inst_mem_resp,
    input  logic [31:0] data_mem_address,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [3:0]  data_mem_byte_enable,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    // Before any conflict, pretend the other side won last so that the
    // configured side wins the first tie.
    localparam arb_side_t LAST_GRANT_INIT = FIRST_GRANT_DATA ? INST : DATA;

    arb_state_t state_q, state_d;
    arb_side_t  grant_q, grant_d;
    arb_side_t  last_grant_q, last_grant_d;
    rv32i_word  rdata_q, rdata_d;

    arb_req_t   req_in;
    arb_req_t   req_q;
    logic       req_load;

    logic       inst_req;
    logic       data_req;
    logic       busy;
    logic       in_resp;

    assign inst_req = inst_mem_read | inst_mem_write;
    assign data_req = data_mem_read | data_mem_write;

    // FSM, grant decision and read-data capture.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        req_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    if (inst_req && data_req) begin
                        if (RR_ENABLE) begin
                            grant_d = (last_grant_q == DATA) ? INST : DATA;
                        end else begin
                            grant_d = DATA;
                        end
                    end else begin
                        grant_d = data_req ? DATA : INST;
                    end
                    req_load = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    rdata_d      = mem_rdata;
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                // Requests still held here are stale; IDLE re-samples next.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the winning side's request for capture (write wins over read).
    always_comb begin
        if (grant_d == DATA) begin
            req_in = '{addr: data_mem_address, be: data_mem_byte_enable,
                       wdata: data_mem_wdata, is_write: data_mem_write};
        end else begin
            req_in = '{addr: inst_mem_address, be: inst_mem_byte_enable,
                       wdata: inst_mem_wdata, is_write: inst_mem_write};
        end
    end

    arb_req_reg u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (req_load),
        .req_in  (req_in),
        .req_out (req_q)
    );

    // Arbiter state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= INST;
            last_grant_q <= LAST_GRANT_INIT;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
        end
    end

    // Physical port is live only while BUSY; everything is low otherwise.
    assign busy            = (state_q == BUSY);
    assign mem_address     = busy ? req_q.addr  : '0;
    assign mem_byte_enable = busy ? req_q.be    : '0;
    assign mem_wdata       = busy ? req_q.wdata : '0;
    assign mem_read        = busy & ~req_q.is_write;
    assign mem_write       = busy &  req_q.is_write;

    // Response pulse and read data go only to the granted side.
    assign in_resp        = (state_q == RESP);
    assign inst_mem_resp  = in_resp && (grant_q == INST);
    assign data_mem_resp  = in_resp && (grant_q == DATA);
    assign inst_mem_rdata = inst_mem_resp ? rdata_q : '0;
    assign data_mem_rdata = data_mem_resp ? rdata_q : '0;

    // A side asserting read and write together is a CPU bug.
    always @(posedge clk) begin
        if (rst && state_q == IDLE) begin
            assert (!(inst_mem_read && inst_mem_write) && !(data_mem_read && data_mem_write));
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps for latency, field capture, conflict
// ordering and reset, then a randomized run checked against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_mem_address, inst_mem_wdata, data_mem_address, data_mem_wdata;
    logic        inst_mem_read, inst_mem_write, data_mem_read, data_mem_write;
    logic [3:0]  inst_mem_byte_enable, data_mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp, f_mem_resp;

    logic [31:0] inst_mem_rdata, data_mem_rdata, mem_address, mem_wdata;
    logic        inst_mem_resp, data_mem_resp, mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] f_inst_mem_rdata, f_data_mem_rdata, f_mem_address, f_mem_wdata;
    logic        f_inst_mem_resp, f_data_mem_resp, f_mem_read, f_mem_write;
    logic [3:0]  f_mem_byte_enable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_ENABLE(1'b1), .FIRST_GRANT_DATA(1'b1)) dut (
        .clk(clk), .rst(rst),
        .inst_mem_address(inst_mem_address), .inst_mem_read(inst_mem_read),
        .inst_mem_write(inst_mem_write), .inst_mem_byte_enable(inst_mem_byte_enable),
        .inst_mem_wdata(inst_mem_wdata), .inst_mem_rdata(inst_mem_rdata),
        .inst_mem_resp(inst_mem_resp),
        .data_mem_address(data_mem_address), .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write), .data_mem_byte_enable(data_mem_byte_enable),
        .data_mem_wdata(data_mem_wdata), .data_mem_rdata(data_mem_rdata),
        .data_mem_resp(data_mem_resp),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_arbiter #(.RR_ENABLE(1'b0), .FIRST_GRANT_DATA(1'b1)) dut_fix (
        .clk(clk), .rst(rst),
        .inst_mem_address(inst_mem_address), .inst_mem_read(inst_mem_read),
        .inst_mem_write(inst_mem_write), .inst_mem_byte_enable(inst_mem_byte_enable),
        .inst_mem_wdata(inst_mem_wdata), .inst_mem_rdata(f_inst_mem_rdata),
        .inst_mem_resp(f_inst_mem_resp),
        .data_mem_address(data_mem_address), .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write), .data_mem_byte_enable(data_mem_byte_enable),
        .data_mem_wdata(data_mem_wdata), .data_mem_rdata(f_data_mem_rdata),
        .data_mem_resp(f_data_mem_resp),
        .mem_address(f_mem_address), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_byte_enable(f_mem_byte_enable), .mem_wdata(f_mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(f_mem_resp)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          wr;
    } req_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_mem_address = '0; inst_mem_read = 1'b0; inst_mem_write = 1'b0;
        inst_mem_byte_enable = '0; inst_mem_wdata = '0;
        data_mem_address = '0; data_mem_read = 1'b0; data_mem_write = 1'b0;
        data_mem_byte_enable = '0; data_mem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Wait (bounded) for the chosen instance to start an access, check who got
    // it, answer after lat strobe cycles, then check the response steering.
    task automatic run_txn(input bit fix, input logic [31:0] exp_addr,
                           input bit exp_data, input int lat, input int exp_wait);
        int waited;
        logic [31:0] rd;
        waited = 0;
        while (!(fix ? (f_mem_read | f_mem_write) : (mem_read | mem_write)) && waited < 20) begin
            tick();
            waited++;
        end
        $display("txn fix=%0d addr=%08h waited=%0d lat=%0d", fix, exp_addr, waited, lat);
        chk("grant_wait", waited, exp_wait);
        chk("grant_addr", fix ? f_mem_address : mem_address, exp_addr);
        for (int i = 1; i < lat; i++) tick();
        rd = $urandom;
        mem_rdata = rd;
        if (fix) f_mem_resp = 1'b1; else mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        f_mem_resp = 1'b0;
        mem_rdata = ~rd;
        chk("resp_data_side", fix ? f_data_mem_resp : data_mem_resp, exp_data);
        chk("resp_inst_side", fix ? f_inst_mem_resp : inst_mem_resp, !exp_data);
        chk("resp_rdata", exp_data ? (fix ? f_data_mem_rdata : data_mem_rdata)
                                   : (fix ? f_inst_mem_rdata : inst_mem_rdata), rd);
    endtask

    // Random-phase model state (index 0 = instruction side, 1 = data side).
    req_t rq [2];
    bit   pend [2];
    bit   hold [2];
    bit   p_prev [2];
    req_t t_req;
    bit   active, resp_due, last_side, t_side, prev_idle, was_busy, resp_now, side;
    int   t_lat, t_cnt;
    logic [31:0] t_rdata;

    task automatic apply_inputs();
        bit on0, on1;
        on0 = pend[0] || hold[0];
        on1 = pend[1] || hold[1];
        inst_mem_address = rq[0].addr; inst_mem_byte_enable = rq[0].be; inst_mem_wdata = rq[0].wdata;
        inst_mem_read = on0 && !rq[0].wr; inst_mem_write = on0 && rq[0].wr;
        data_mem_address = rq[1].addr; data_mem_byte_enable = rq[1].be; data_mem_wdata = rq[1].wdata;
        data_mem_read = on1 && !rq[1].wr; data_mem_write = on1 && rq[1].wr;
    endtask

    initial begin
        clear_inputs();
        mem_resp = 1'b0; f_mem_resp = 1'b0; mem_rdata = '0;

        // Reset state.
        #3;
        chk("reset_mem_read", mem_read, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_mem_address", mem_address, 0);
        chk("reset_mem_be", mem_byte_enable, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_inst_resp", inst_mem_resp, 0);
        chk("reset_data_resp", data_mem_resp, 0);
        tick();
        tick();
        rst = 1'b1;

        // Single fetch, memory answers at cycle 3, stale read held through RESP.
        inst_mem_read = 1'b1; inst_mem_address = 32'h60; inst_mem_byte_enable = 4'hF;
        tick();
        $display("fetch cycle1 mem_read=%0d addr=%08h", mem_read, mem_address);
        chk("fetch_c1_read", mem_read, 1);
        chk("fetch_c1_write", mem_write, 0);
        chk("fetch_c1_addr", mem_address, 32'h60);
        tick();
        chk("fetch_c2_read", mem_read, 1);
        chk("fetch_c2_resp", inst_mem_resp, 0);
        tick();
        chk("fetch_c3_read", mem_read, 1);
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        mem_resp = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        $display("fetch cycle4 inst_resp=%0d rdata=%08h", inst_mem_resp, inst_mem_rdata);
        chk("fetch_c4_resp", inst_mem_resp, 1);
        chk("fetch_c4_rdata", inst_mem_rdata, 32'h0000_0013);
        chk("fetch_c4_data_resp", data_mem_resp, 0);
        chk("fetch_c4_read_low", mem_read, 0);
        tick();
        inst_mem_read = 1'b0;
        chk("fetch_c5_pulse_end", inst_mem_resp, 0);
        chk("fetch_c5_rdata_zero", inst_mem_rdata, 0);
        chk("stale_c5_no_read", mem_read, 0);
        tick();
        chk("stale_c6_no_read", mem_read, 0);
        chk("stale_c6_data_resp", data_mem_resp, 0);

        // Data write; CPU-side changes during BUSY must not leak through.
        data_mem_write = 1'b1; data_mem_address = 32'h100;
        data_mem_byte_enable = 4'b0011; data_mem_wdata = 32'hDEAD_BEEF;
        tick();
        $display("write cycle1 mem_write=%0d addr=%08h be=%h wdata=%08h",
                 mem_write, mem_address, mem_byte_enable, mem_wdata);
        chk("wr_write", mem_write, 1);
        chk("wr_read", mem_read, 0);
        chk("wr_addr", mem_address, 32'h100);
        chk("wr_be", mem_byte_enable, 4'b0011);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        data_mem_address = 32'h200; data_mem_byte_enable = 4'hF; data_mem_wdata = 32'h0;
        tick();
        chk("wr_hold_addr", mem_address, 32'h100);
        chk("wr_hold_be", mem_byte_enable, 4'b0011);
        chk("wr_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_resp = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_resp = 1'b0; mem_rdata = 32'h0; data_mem_write = 1'b0;
        chk("wr_data_resp", data_mem_resp, 1);
        chk("wr_data_rdata", data_mem_rdata, 32'hCAFE_0001);
        chk("wr_inst_resp", inst_mem_resp, 0);
        chk("wr_inst_rdata", inst_mem_rdata, 0);
        tick();
        tick();
        chk("wr_after_idle", mem_write, 0);

        // Round robin from reset: data first, then strict alternation.
        do_reset();
        inst_mem_read = 1'b1; inst_mem_address = 32'h1000;
        data_mem_read = 1'b1; data_mem_address = 32'h2000;
        run_txn(1'b0, 32'h2000, 1'b1, 1, 1);
        run_txn(1'b0, 32'h1000, 1'b0, 2, 2);
        run_txn(1'b0, 32'h2000, 1'b1, 3, 2);
        run_txn(1'b0, 32'h1000, 1'b0, 1, 2);
        clear_inputs();
        tick();

        // Fixed priority: data always wins; inst gets the next IDLE once data drops.
        do_reset();
        inst_mem_read = 1'b1; inst_mem_address = 32'h1000;
        data_mem_read = 1'b1; data_mem_address = 32'h2000;
        run_txn(1'b1, 32'h2000, 1'b1, 1, 1);
        run_txn(1'b1, 32'h2000, 1'b1, 2, 2);
        run_txn(1'b1, 32'h2000, 1'b1, 1, 2);
        data_mem_read = 1'b0;
        run_txn(1'b1, 32'h1000, 1'b0, 2, 2);
        clear_inputs();
        tick();

        // Reset in the middle of an access clears outputs without a clock edge.
        do_reset();
        inst_mem_read = 1'b1; inst_mem_address = 32'h60;
        tick();
        chk("rstmid_busy", mem_read, 1);
        #2 rst = 1'b0;
        #1;
        $display("async reset mem_read=%0d addr=%08h", mem_read, mem_address);
        chk("rstmid_read", mem_read, 0);
        chk("rstmid_addr", mem_address, 0);
        chk("rstmid_fix_read", f_mem_read, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        inst_mem_read = 1'b0;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        tick();
        chk("late_resp_inst", inst_mem_resp, 0);
        chk("late_resp_data", data_mem_resp, 0);
        chk("late_resp_read", mem_read, 0);

        // Randomized traffic against the transaction-level model.
        clear_inputs();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            rq[s] = '{addr: 32'h0, be: 4'h0, wdata: 32'h0, wr: 1'b0};
            pend[s] = 1'b0; hold[s] = 1'b0; p_prev[s] = 1'b0;
        end
        active = 1'b0; resp_due = 1'b0; last_side = 1'b0; t_side = 1'b0;
        prev_idle = 1'b1; t_lat = 0; t_cnt = 0; t_rdata = '0;
        t_req = rq[0];
        for (int n = 0; n < 800; n++) begin
            tick();
            // Responses: one pulse, one cycle after mem_resp, to the granted side.
            chk("rnd_inst_resp", inst_mem_resp, resp_due && !t_side);
            chk("rnd_data_resp", data_mem_resp, resp_due && t_side);
            chk("rnd_inst_rdata", inst_mem_rdata, (resp_due && !t_side) ? t_rdata : 32'h0);
            chk("rnd_data_rdata", data_mem_rdata, (resp_due && t_side) ? t_rdata : 32'h0);
            resp_now = resp_due;
            resp_due = 1'b0;
            // A new access starts only after a cycle in IDLE that saw a request.
            was_busy = active;
            if (!active) begin
                chk("rnd_start", mem_read | mem_write, prev_idle && (p_prev[0] || p_prev[1]));
                if (mem_read | mem_write) begin
                    side = (p_prev[0] && p_prev[1]) ? !last_side : p_prev[1];
                    t_side = side;
                    t_req = rq[side];
                    t_lat = int'($urandom_range(4, 1));
                    t_cnt = 0;
                    active = 1'b1;
                    was_busy = 1'b1;
                    $display("rnd txn n=%0d side=%0d addr=%08h wr=%0d lat=%0d",
                             n, side, t_req.addr, t_req.wr, t_lat);
                end
            end
            if (active) begin
                chk("rnd_mem_read", mem_read, !t_req.wr);
                chk("rnd_mem_write", mem_write, t_req.wr);
                chk("rnd_mem_addr", mem_address, t_req.addr);
                chk("rnd_mem_be", mem_byte_enable, t_req.be);
                chk("rnd_mem_wdata", mem_wdata, t_req.wdata);
                t_cnt++;
                if (t_cnt == t_lat) begin
                    t_rdata = $urandom;
                    mem_rdata = t_rdata;
                    mem_resp = 1'b1;
                    resp_due = 1'b1;
                    active = 1'b0;
                    last_side = t_side;
                end else begin
                    mem_resp = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                // Stray completions outside an access must be ignored.
                mem_resp = ($urandom_range(4, 0) == 0);
                mem_rdata = $urandom;
            end
            prev_idle = !was_busy && !resp_now;
            // Requesters: hold until served, optionally keep a stale strobe
            // through the response cycle, then maybe issue something new.
            for (int s = 0; s < 2; s++) begin
                if (resp_now && (t_side == s[0])) begin
                    pend[s] = 1'b0;
                    hold[s] = $urandom_range(1, 0) == 1;
                end else if (hold[s]) begin
                    hold[s] = 1'b0;
                end
                if (!pend[s] && !hold[s]) begin
                    rq[s].addr  = $urandom;
                    rq[s].be    = 4'($urandom);
                    rq[s].wdata = $urandom;
                    rq[s].wr    = $urandom_range(1, 0) == 1;
                    pend[s] = $urandom_range(2, 0) == 0;
                end
                p_prev[s] = pend[s];
            end
            apply_inputs();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Merges the CPU's split instruction and data memory ports onto one physical memory port.
- Sits directly downstream of mp4/cpu: consumes inst_mem_* and data_mem_* and drives a single mem_* port toward the memory model or cache.
- One transaction is outstanding at a time. Requests are latched at grant, and the response is returned as a registered one-cycle pulse to the requester that was granted.
- Round-robin arbitration prevents instruction-fetch starvation during heavy load/store traffic.

Parameters:
- RR_ENABLE, 1: 1 selects round-robin on conflict; 0 selects fixed data-side priority.
- FIRST_GRANT_DATA, 1: the side that wins the first conflict after reset when RR_ENABLE=1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- inst_mem_address  in  32  instruction-side request address (rv32i_word).
- inst_mem_read / inst_mem_write  in  1  instruction-side request strobes, held until inst_mem_resp.
- inst_mem_byte_enable  in  4  instruction-side byte enables.
- inst_mem_wdata  in  32  instruction-side write data.
- inst_mem_rdata  out  32  instruction-side read data, valid while inst_mem_resp is high.
- inst_mem_resp  out  1  one-cycle completion pulse to the instruction side.
- data_mem_address, data_mem_read, data_mem_write, data_mem_byte_enable, data_mem_wdata  in  32/1/1/4/32  data-side request; same rules as the instruction side.
- data_mem_rdata  out  32  data-side read data, valid while data_mem_resp is high.
- data_mem_resp  out  1  one-cycle completion pulse to the data side.
- mem_address  out  32  physical-port address, driven from the request register.
- mem_read / mem_write  out  1  physical-port strobes.
- mem_byte_enable  out  4  physical-port byte enables.
- mem_wdata  out  32  physical-port write data.
- mem_rdata  in  32  physical-port read data.
- mem_resp  in  1  physical-port completion.

Behaviour:
- States: IDLE, BUSY, RESP. Registers: grant (INST/DATA), last_grant, req_reg {addr, be, wdata, is_write}, rdata_reg.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; req_reg and rdata_reg clear to 0.
  - last_grant takes the value opposite FIRST_GRANT_DATA.
  - All outputs go to 0: mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, both resp signals and both rdata signals.
  - Any in-flight physical transaction is abandoned. A mem_resp arriving afterwards while in IDLE is ignored.
- IDLE:
  - A side is requesting when its read or write strobe is high.
  - Only one side requesting: grant it.
  - Both requesting: if RR_ENABLE=1, grant the side that is not last_grant; otherwise grant DATA.
  - On grant, capture the winner's address, byte_enable and wdata into req_reg. Set is_write = write (write wins if both strobes are high; a simulation assertion flags this). Go to BUSY.
  - No requester: stay in IDLE. mem_* outputs stay low in IDLE.
- BUSY:
  - mem_address, mem_byte_enable and mem_wdata are driven from req_reg. mem_read = !is_write, mem_write = is_write.
  - Changes on the CPU inputs during BUSY are ignored.
  - On mem_resp=1: capture mem_rdata into rdata_reg, set last_grant = grant, go to RESP. Strobes drop in the RESP cycle.
- RESP (exactly one cycle):
  - Assert the granted side's *_resp = 1; that side's *_rdata = rdata_reg.
  - The other side's resp stays 0 and its rdata stays 0.
  - Always return to IDLE.
  - IDLE re-samples requests the cycle after the resp pulse, so a stale request still held during RESP is never re-issued.
- Latency:
  - Request sampled in IDLE at cycle 0; mem_read/mem_write high from cycle 1.
  - mem_resp at cycle k ≥ 1 gives the requester's resp at cycle k+1.
  - Minimum request-to-resp latency is 2 cycles. Back-to-back throughput is 1 transaction per (mem latency + 2) cycles.
- The losing requester keeps its strobe held and is granted in the next IDLE cycle. Its rdata/resp are never disturbed by the other side's transaction.
- mem_resp outside BUSY is ignored.

Decomposition:
- rv32i_types (shared package): rv32i_word already lives here; add arb_state_t (IDLE/BUSY/RESP) and arb_side_t (INST/DATA).
- One natural sub-module, arb_req_reg: the request-capture register with load enable and async active-low clear. It holds addr/be/wdata/is_write.
- The FSM, grant logic and response steering remain in mem_arbiter.

Test Plan:
- Single fetch: inst_mem_read=1, addr 0x60; memory returns 0x00000013 after 3 cycles → mem_read high cycles 1–3, mem_resp at cycle 3, inst_mem_resp=1 with inst_mem_rdata=0x00000013 at cycle 4 only, data_mem_resp=0 throughout.
- Conflict with round robin: both read in the same cycle from reset (FIRST_GRANT_DATA=1) → data served first and inst served second. Repeating with both held gives strict alternation.
- RR_ENABLE=0, data held continuously plus inst requesting → every grant goes to DATA. When data drops, inst is granted the next IDLE cycle.
- Data write: addr 0x100, be 4'b0011, wdata 0xDEADBEEF → mem_write=1 with the identical address, byte enables and data. Changing the CPU inputs during BUSY does not alter mem_*.
- Stale request: requester holds read through its resp cycle → no duplicate transaction is issued; the next grant occurs only in the cycle after RESP.
- Reset mid-BUSY: rst=0 while mem_read=1 → all outputs go to 0 immediately (asynchronously). After release, a late mem_resp produces no *_resp pulse.
